// File: rtl/reg_write_buffer_if.sv
// Register write buffer bus.
// Groups the writeback offer handshake, the register-file drain port, the
// decode read-port forwarding lookups and the occupancy count.
//   master : producer / decode / register-file side (drives offers, drain_en, read numbers)
//   slave  : the buffer itself (drives in_ready, write port, forwarding results, count)
interface reg_write_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic [4:0]      in_reg_num;
  logic [31:0]     in_data;
  logic            in_ready;
  logic            drain_en;
  logic [4:0]      Write_Reg_Num;
  logic [31:0]     Write_Data;
  logic            RegWrite;
  logic [4:0]      Read_Reg_Num_1;
  logic [4:0]      Read_Reg_Num_2;
  logic            fwd_hit_1;
  logic            fwd_hit_2;
  logic [31:0]     fwd_data_1;
  logic [31:0]     fwd_data_2;
  logic [CntW-1:0] count;

  modport master (
    output in_valid, in_reg_num, in_data, drain_en, Read_Reg_Num_1, Read_Reg_Num_2,
    input  in_ready, Write_Reg_Num, Write_Data, RegWrite,
    input  fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2, count
  );

  modport slave (
    input  in_valid, in_reg_num, in_data, drain_en, Read_Reg_Num_1, Read_Reg_Num_2,
    output in_ready, Write_Reg_Num, Write_Data, RegWrite,
    output fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2, count
  );
endinterface

// File: rtl/reg_write_buffer.sv
// Pending register-write buffer between writeback and the register file.
// Writes are queued in order, drained one per cycle whenever the register
// file write port is free, and the youngest pending value of any register is
// forwarded to the two decode read ports.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : reg_write_buffer_if.slave (offer handshake, drain port, forwarding, count)
// DEPTH must be a power of two in 2..16 so the pointers wrap naturally.
module reg_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  reg_write_buffer_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [4:0]      reg_q  [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q, count_d;

  logic in_ready;
  logic enq;
  logic deq;

  // in_ready depends only on registered occupancy, never on this cycle's drain.
  assign in_ready = count_q < CntW'(DEPTH);
  // Writes to r0 complete the handshake but are dropped.
  assign enq      = bus.in_valid && in_ready && (bus.in_reg_num != 5'd0);
  assign deq      = (count_q != '0) && bus.drain_en;

  always_comb begin
    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      if (enq) begin
        reg_q[tail_q]  <= bus.in_reg_num;
        data_q[tail_q] <= bus.in_data;
        tail_q         <= tail_q + 1'b1;
      end
      if (deq) begin
        head_q <= head_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Forwarding: walk entries oldest to youngest so the last match wins.
  // Only registered entries are searched; the head being drained still counts.
  logic            hit_1, hit_2;
  logic [31:0]     fdata_1, fdata_2;
  logic [PtrW-1:0] idx;

  always_comb begin
    hit_1   = 1'b0;
    hit_2   = 1'b0;
    fdata_1 = 32'd0;
    fdata_2 = 32'd0;
    idx     = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (CntW'(i) < count_q) begin
        if ((bus.Read_Reg_Num_1 != 5'd0) && (reg_q[idx] == bus.Read_Reg_Num_1)) begin
          hit_1   = 1'b1;
          fdata_1 = data_q[idx];
        end
        if ((bus.Read_Reg_Num_2 != 5'd0) && (reg_q[idx] == bus.Read_Reg_Num_2)) begin
          hit_2   = 1'b1;
          fdata_2 = data_q[idx];
        end
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.RegWrite      = deq;
  assign bus.Write_Reg_Num = (count_q != '0) ? reg_q[head_q]  : 5'd0;
  assign bus.Write_Data    = (count_q != '0) ? data_q[head_q] : 32'd0;
  assign bus.fwd_hit_1     = hit_1;
  assign bus.fwd_hit_2     = hit_2;
  assign bus.fwd_data_1    = fdata_1;
  assign bus.fwd_data_2    = fdata_2;
  assign bus.count         = count_q;
endmodule
